// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit bridging execute-stage memory requests to a valid/ready data bus (optional LSU_TIMEOUT_EN bus timeout)
module lsu_mem_port #(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              stall,
    output logic [DWIDTH-1:0] DataR,
    output logic              resp_valid,
    output logic              fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [AWIDTH-1:0] bus_addr,
    output logic [DWIDTH-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [DWIDTH-1:0] bus_rdata,
    input  logic              bus_rvalid
);

    // The lane/extension logic below is written for four byte lanes.
    if (DWIDTH != 32) begin : g_dwidth_check
        $error("lsu_mem_port supports DWIDTH=32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("lsu_mem_port needs TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t            state_q;
    logic              req_we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        a_q;
    logic [DWIDTH-1:0] data_r_q;
    logic              resp_valid_q;
    logic              fault_q;
    logic              bus_valid_q;
    logic              bus_we_q;
    logic [AWIDTH-1:0] bus_addr_q;
    logic [DWIDTH-1:0] bus_wdata_q;
    logic [3:0]        bus_wstrb_q;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
`endif

    logic              legal_d;
    logic              aligned_d;
    logic [3:0]        wstrb_d;
    logic [DWIDTH-1:0] wdata_d;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DWIDTH-1:0] load_d;

    // Request decode: legality, alignment, byte strobes and lane-replicated store data.
    always_comb begin
        legal_d   = 1'b0;
        aligned_d = 1'b0;
        case (funct3)
            3'b000: begin legal_d = 1'b1;    aligned_d = 1'b1;               end
            3'b001: begin legal_d = 1'b1;    aligned_d = ~addr[0];           end
            3'b010: begin legal_d = 1'b1;    aligned_d = (addr[1:0] == 2'b00); end
            3'b100: begin legal_d = ~req_we; aligned_d = 1'b1;               end
            3'b101: begin legal_d = ~req_we; aligned_d = ~addr[0];           end
            default: begin legal_d = 1'b0;   aligned_d = 1'b0;               end
        endcase
        wstrb_d = 4'b0000;
        wdata_d = '0;
        if (req_we) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_d = 4'b0001 << addr[1:0];
                    wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                    wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                    wstrb_d = 4'b1111;
                    wdata_d = wdata;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension using the latched request.
    always_comb begin
        case (a_q)
            2'd0:    lane_b = bus_rdata[7:0];
            2'd1:    lane_b = bus_rdata[15:8];
            2'd2:    lane_b = bus_rdata[23:16];
            default: lane_b = bus_rdata[31:24];
        endcase
        lane_h = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_d = {{24{~funct3_q[2] & lane_b[7]}}, lane_b};
            2'b01:   load_d = {{16{~funct3_q[2] & lane_h[15]}}, lane_h};
            default: load_d = bus_rdata;
        endcase
    end

    // Main FSM: all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            funct3_q     <= 3'b000;
            a_q          <= 2'b00;
            data_r_q     <= '0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (legal_d && aligned_d) begin
                            req_we_q    <= req_we;
                            funct3_q    <= funct3;
                            a_q         <= addr[1:0];
                            bus_valid_q <= 1'b1;
                            bus_we_q    <= req_we;
                            bus_addr_q  <= {addr[AWIDTH-1:2], 2'b00};
                            bus_wdata_q <= wdata_d;
                            bus_wstrb_q <= wstrb_d;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                            state_q     <= REQ;
                        end else begin
                            fault_q      <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid_q <= 1'b0;
                        if (req_we_q) begin
                            fault_q      <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
`ifdef LSU_TIMEOUT_EN
                            cnt_q        <= '0;
`endif
                            state_q      <= WAIT_R;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        bus_valid_q  <= 1'b0;
                        fault_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        data_r_q     <= load_d;
                        fault_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        fault_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The pipeline is released in the DONE cycle so it advances exactly once per access.
    assign stall      = req_valid & (state_q != DONE);
    assign DataR      = data_r_q;
    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;

endmodule
